// File: rtl/line_window3.sv
// Three-row line buffer: stores the two previous image rows and emits aligned
// {top, mid, bot} column triples for every pixel from row 2 onward.
module line_window3 #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 48,
  parameter int CW    = $clog2(IMG_W),
  parameter int RW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_pix,
  input  logic          in_sof,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [31:0]   top_pix,
  output logic [31:0]   mid_pix,
  output logic [31:0]   bot_pix,
  output logic [CW-1:0] out_col,
  output logic [RW-1:0] out_row,
  output logic          out_sol,
  output logic          out_eol,
  output logic          frame_done
);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_e;

  typedef struct packed {
    logic [31:0]   top;
    logic [31:0]   mid;
    logic [31:0]   bot;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          sol;
    logic          eol;
  } triple_t;

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          ov_q, ov_d;
  logic          fd_q, fd_d;
  triple_t       tri_q, tri_d;

  logic [31:0] lb0_q [IMG_W];
  logic [31:0] lb1_q [IMG_W];

  logic          rdy_st;
  logic          acc;
  logic          last_col;
  logic          lb_we;
  logic [CW-1:0] wr_col;

  always_comb begin
    rdy_st = 1'b0;
    case (state_q)
      IDLE:    rdy_st = 1'b1;
      FILL:    rdy_st = 1'b1;
      STREAM:  rdy_st = !ov_q || out_ready;
      default: rdy_st = 1'b0;
    endcase
  end

  assign in_ready = !rst && rdy_st;
  assign acc      = in_valid && in_ready;
  assign last_col = (col_q == CW'(IMG_W - 1));
  // A start-of-frame pixel always lands in column 0, whatever the counter says.
  assign wr_col   = in_sof ? '0 : col_q;
  assign lb_we    = acc && (in_sof || state_q != IDLE);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    ov_d    = ov_q;
    fd_d    = 1'b0;
    tri_d   = tri_q;
    case (state_q)
      IDLE: begin
        if (acc && in_sof) begin
          col_d   = CW'(1);
          row_d   = '0;
          state_d = FILL;
        end
      end
      FILL, STREAM: begin
        if (acc && in_sof) begin
          ov_d    = 1'b0;
          col_d   = CW'(1);
          row_d   = '0;
          state_d = FILL;
        end else if (acc) begin
          if (state_q == STREAM) begin
            ov_d      = 1'b1;
            tri_d.top = lb1_q[col_q];
            tri_d.mid = lb0_q[col_q];
            tri_d.bot = in_pix;
            tri_d.col = col_q;
            tri_d.row = row_q;
            tri_d.sol = (col_q == '0);
            tri_d.eol = last_col;
          end
          if (last_col) begin
            col_d = '0;
            if (state_q == FILL && row_q == RW'(1)) begin
              row_d   = RW'(2);
              state_d = STREAM;
            end else if (state_q == STREAM && row_q == RW'(IMG_H - 1)) begin
              state_d = DRAIN;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end else if (state_q == STREAM && out_ready) begin
          ov_d = 1'b0;
        end
      end
      default: begin
        if (ov_q && out_ready) begin
          ov_d    = 1'b0;
          fd_d    = 1'b1;
          row_d   = '0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      ov_q    <= 1'b0;
      fd_q    <= 1'b0;
      tri_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ov_q    <= ov_d;
      fd_q    <= fd_d;
      tri_q   <= tri_d;
    end
  end

  // Line memories need no reset: every column is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb1_q[wr_col] <= lb0_q[wr_col];
      lb0_q[wr_col] <= in_pix;
    end
  end

  assign out_valid  = ov_q;
  assign frame_done = fd_q;
  assign top_pix    = tri_q.top;
  assign mid_pix    = tri_q.mid;
  assign bot_pix    = tri_q.bot;
  assign out_col    = tri_q.col;
  assign out_row    = tri_q.row;
  assign out_sol    = tri_q.sol;
  assign out_eol    = tri_q.eol;

endmodule

// File: tb/tb_line_window3.sv
// Randomized check of line_window3 against a frame-position reference model
// that stores accepted pixels as a 2-D image and derives triples from it.
module tb_line_window3;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, in_sof, out_ready, out_valid;
  logic [31:0]   in_pix, top_pix, mid_pix, bot_pix;
  logic [CW-1:0] out_col;
  logic [RW-1:0] out_row;
  logic          out_sol, out_eol, frame_done;

  always #5 clk = ~clk;

  line_window3 #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pix(in_pix), .in_sof(in_sof), .out_ready(out_ready),
    .out_valid(out_valid), .top_pix(top_pix), .mid_pix(mid_pix),
    .bot_pix(bot_pix), .out_col(out_col), .out_row(out_row),
    .out_sol(out_sol), .out_eol(out_eol), .frame_done(frame_done)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Model: pixels accepted in the current frame, indexed by linear position.
  bit          m_act;
  int          m_pos;
  bit          m_ov, m_fd, m_sol, m_eol;
  logic [31:0] m_top, m_mid, m_bot;
  int          m_col, m_row, n_frames;
  logic [31:0] img [H][W];

  task automatic step(input bit r, input bit v, input bit s, input logic [31:0] p, input bit o);
    bit rdy, acc;
    int y, c;
    rst = r; in_valid = v; in_sof = s; in_pix = p; out_ready = o;
    #1;
    if (r)                rdy = 1'b0;
    else if (!m_act)      rdy = 1'b1;
    else if (m_pos < 2*W) rdy = 1'b1;
    else if (m_pos < W*H) rdy = !m_ov || o;
    else                  rdy = 1'b0;
    chk("in_ready", in_ready, rdy);
    acc  = v && rdy;
    m_fd = 1'b0;
    if (r) begin
      m_act = 0; m_pos = 0; m_ov = 0; m_top = 0; m_mid = 0; m_bot = 0;
      m_col = 0; m_row = 0; m_sol = 0; m_eol = 0;
    end else if (acc && s) begin
      m_act = 1; m_pos = 1; m_ov = 0; img[0][0] = p;
    end else if (acc && m_act) begin
      y = m_pos / W;
      c = m_pos % W;
      img[y][c] = p;
      if (y >= 2) begin
        m_ov = 1; m_top = img[y-2][c]; m_mid = img[y-1][c]; m_bot = p;
        m_col = c; m_row = y; m_sol = (c == 0); m_eol = (c == W-1);
      end
      m_pos++;
    end else if (!acc && m_ov && o) begin
      m_ov = 0;
      if (m_act && m_pos == W*H) begin
        m_fd = 1; m_act = 0; n_frames++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", out_valid, m_ov);
    chk("frame_done", frame_done, m_fd);
    if (m_ov || r) begin
      chk("top_pix", top_pix, m_top);
      chk("mid_pix", mid_pix, m_mid);
      chk("bot_pix", bot_pix, m_bot);
      chk("out_col", out_col, m_col);
      chk("out_row", out_row, m_row);
      chk("out_sol", out_sol, m_sol);
      chk("out_eol", out_eol, m_eol);
    end
  endtask

  initial begin
    bit s, v, o, r, busy;
    rst = 1; in_valid = 0; in_sof = 0; in_pix = 0; out_ready = 0;
    n_frames = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 32'h55, 1);
    // Directed frame, pixel = row*16+col, full rate.
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        step(0, 1, (y == 0 && x == 0), 32'(y*16 + x), 1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1);
    // Directed frame with IDLE junk and backpressure at stream col 1.
    for (int k = 0; k < 5; k++) step(0, 1, 0, 32'hdead0000 + 32'(k), 1);
    for (int i = 0; i < W*H; i++) begin
      step(0, 1, (i == 0), 32'((i/W)*16 + i%W), 1);
      if (i == 2*W + 1)
        for (int k = 0; k < 3; k++) step(0, 1, 0, 32'((i+1)/W*16 + (i+1)%W), 0);
    end
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1);
    // Random traffic with occasional aborts and resets.
    for (int k = 0; k < 6000; k++) begin
      busy = m_act;
      r = ($urandom_range(0, 399) == 0);
      v = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 3) != 0);
      s = busy ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 2) == 0);
      step(r, v, s, $urandom, o);
    end
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
